instr_encoder: RTL and testbench

//  Inverse of the core's instruction decode path: encodes RV32I instruction requests into
//  32-bit words and writes them sequentially into instruction memory (program loader / test driver).

---
 rtl/instr_encoder_if.sv | 31 +++
 rtl/instr_encoder.sv | 217 +++++++++++++++++++++
 tb/tb_instr_encoder.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_if.sv
// Request and instruction-memory write bundle for instr_encoder.
//   req_*    : valid/ready request carrying one RV32I instruction description
//              (kind, ALU op, register numbers, signed byte immediate).
//   wr_*     : imem write port; wr_en/wr_addr/wr_data are held until wr_ready.
// master = request producer / imem side, slave = the encoder.
interface instr_encoder_if #(
  parameter int ADDR_W = 8
) ();
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_kind;
  logic [2:0]        req_alu;
  logic [4:0]        req_rd;
  logic [4:0]        req_rs1;
  logic [4:0]        req_rs2;
  logic [31:0]       req_imm;
  logic              wr_en;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  modport master (
    output req_valid, req_kind, req_alu, req_rd, req_rs1, req_rs2, req_imm, wr_ready,
    input  req_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  req_valid, req_kind, req_alu, req_rd, req_rs1, req_rs2, req_imm, wr_ready,
    output req_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/instr_encoder.sv
// RV32I instruction encoder / imem loader.
// Accepts instruction requests (R/I-ALU, lw, sw, beq, jal), encodes and checks
// them in one registered stage, queues legal words in a DEPTH-entry FIFO and
// writes them to consecutive imem word addresses starting at BASE.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   flush        : synchronous clear back to the post-reset state
//   bus          : request port and imem write port (instr_encoder_if.slave)
//   count        : words written since reset/flush, saturating at 2^ADDR_W
//   err/err_code : sticky error flag and first error (01 alu, 10 imm, 11 kind)
module instr_encoder #(
  parameter int                DEPTH  = 4,
  parameter int                ADDR_W = 8,
  parameter logic [ADDR_W-1:0] BASE   = '0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush,
  instr_encoder_if.slave       bus,
  output logic [ADDR_W:0]      count,
  output logic                 err,
  output logic [1:0]           err_code
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [ADDR_W:0] COUNT_SAT = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    K_R = 3'd0, K_I = 3'd1, K_LW = 3'd2, K_SW = 3'd3, K_BEQ = 3'd4, K_JAL = 3'd5
  } kind_e;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] E_NONE = 2'b00;
  localparam logic [1:0] E_ALU  = 2'b01;
  localparam logic [1:0] E_IMM  = 2'b10;
  localparam logic [1:0] E_KIND = 2'b11;

  // Encode/check stage
  logic             stage_valid_q, stage_valid_d;
  logic [31:0]      stage_word_q,  stage_word_d;
  logic [1:0]       stage_err_q,   stage_err_d;
  // FIFO bookkeeping
  logic [31:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q,    occ_d;
  // Write-side state
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_q,   err_d;
  logic [1:0]        err_code_q, err_code_d;

  logic [31:0] enc_word;
  logic [1:0]  enc_err;
  logic [2:0]  f3_alu;
  logic        alu_ok, is_sub, imm12_ok, b_ok, j_ok;
  logic [31:0] imm;
  logic        accept, push, pop;
  logic [OCC_W-1:0] occ_plus_stage;

  assign imm    = bus.req_imm;
  assign is_sub = (bus.req_alu == 3'b001);

  // Combinational encode of the request currently presented.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    f3_alu   = 3'b000;
    alu_ok   = 1'b0;
    enc_word = '0;
    enc_err  = E_NONE;
    case (bus.req_alu)
      3'b000:  begin f3_alu = 3'b000; alu_ok = 1'b1; end  // add
      3'b001:  begin f3_alu = 3'b000; alu_ok = 1'b1; end  // sub
      3'b010:  begin f3_alu = 3'b111; alu_ok = 1'b1; end  // and
      3'b011:  begin f3_alu = 3'b110; alu_ok = 1'b1; end  // or
      3'b101:  begin f3_alu = 3'b010; alu_ok = 1'b1; end  // slt
      default: begin f3_alu = 3'b000; alu_ok = 1'b0; end
    endcase
    imm12_ok = ($signed(imm) >= -32'sd2048) && ($signed(imm) <= 32'sd2047);
    b_ok     = ($signed(imm) >= -32'sd4096) && ($signed(imm) <= 32'sd4094) && !imm[0];
    j_ok     = ($signed(imm) >= -32'sd1048576) && ($signed(imm) <= 32'sd1048574) && !imm[0];

    // Checks inside each arm are ordered alu before imm so the priority falls out.
    case (bus.req_kind)
      K_R: begin
        enc_word = {(is_sub ? 7'b0100000 : 7'b0000000), bus.req_rs2, bus.req_rs1,
                    f3_alu, bus.req_rd, OP_R};
        if (!alu_ok) enc_err = E_ALU;
      end
      K_I: begin
        enc_word = {imm[11:0], bus.req_rs1, f3_alu, bus.req_rd, OP_I};
        if (!alu_ok || is_sub) enc_err = E_ALU;
        else if (!imm12_ok)    enc_err = E_IMM;
      end
      K_LW: begin
        enc_word = {imm[11:0], bus.req_rs1, 3'b010, bus.req_rd, OP_LW};
        if (!imm12_ok) enc_err = E_IMM;
      end
      K_SW: begin
        enc_word = {imm[11:5], bus.req_rs2, bus.req_rs1, 3'b010, imm[4:0], OP_SW};
        if (!imm12_ok) enc_err = E_IMM;
      end
      K_BEQ: begin
        enc_word = {imm[12], imm[10:5], bus.req_rs2, bus.req_rs1, 3'b000,
                    imm[4:1], imm[11], OP_BEQ};
        if (!b_ok) enc_err = E_IMM;
      end
      K_JAL: begin
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], bus.req_rd, OP_JAL};
        if (!j_ok) enc_err = E_IMM;
      end
      default: enc_err = E_KIND;
    endcase
  end

  // Counting the stage word against capacity guarantees it always has a FIFO
  // slot when it drains, so the stage never has to stall.
  assign occ_plus_stage = occ_q + OCC_W'(stage_valid_q);
  assign bus.req_ready  = reset_n && !flush && (occ_plus_stage < OCC_W'(DEPTH));
  assign accept         = bus.req_valid && bus.req_ready;
  assign push           = stage_valid_q && (stage_err_q == E_NONE);
  assign pop            = bus.wr_en && bus.wr_ready;

  assign bus.wr_en   = (occ_q != '0);
  assign bus.wr_addr = addr_q;
  assign bus.wr_data = bus.wr_en ? mem_q[rd_ptr_q] : 32'h0;
  assign count       = count_q;
  assign err         = err_q;
  assign err_code    = err_code_q;

  always_comb begin
    stage_valid_d = stage_valid_q;
    stage_word_d  = stage_word_q;
    stage_err_d   = stage_err_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    occ_d         = occ_q;
    addr_d        = addr_q;
    count_d       = count_q;
    err_d         = err_q;
    err_code_d    = err_code_q;
    if (flush) begin
      stage_valid_d = 1'b0;
      stage_word_d  = '0;
      stage_err_d   = E_NONE;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      occ_d         = '0;
      addr_d        = BASE;
      count_d       = '0;
      err_d         = 1'b0;
      err_code_d    = E_NONE;
    end else begin
      stage_valid_d = accept;
      if (accept) begin
        stage_word_d = enc_word;
        stage_err_d  = enc_err;
      end
      // Illegal words die in the stage; only the first error code is kept.
      if (stage_valid_q && (stage_err_q != E_NONE) && !err_q) begin
        err_d      = 1'b1;
        err_code_d = stage_err_q;
      end
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        addr_d   = addr_q + 1'b1;
        if (count_q != COUNT_SAT) count_d = count_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   occ_d = occ_q + 1'b1;
        2'b01:   occ_d = occ_q - 1'b1;
        default: occ_d = occ_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_valid_q <= 1'b0;
      stage_word_q  <= '0;
      stage_err_q   <= E_NONE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      occ_q         <= '0;
      addr_q        <= BASE;
      count_q       <= '0;
      err_q         <= 1'b0;
      err_code_q    <= E_NONE;
    end else begin
      stage_valid_q <= stage_valid_d;
      stage_word_q  <= stage_word_d;
      stage_err_q   <= stage_err_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      occ_q         <= occ_d;
      addr_q        <= addr_d;
      count_q       <= count_d;
      err_q         <= err_d;
      err_code_q    <= err_code_d;
    end
  end

  // NOTE: FIFO storage has no reset; occupancy gates every read and wr_data.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= stage_word_q;
  end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;
  localparam int              DEPTH  = 4;
  localparam int              ADDR_W = 8;
  localparam logic [ADDR_W-1:0] BASE = 8'h00;

  typedef struct {
    int kind; int alu; int rd; int rs1; int rs2; int imm;
  } req_t;

  typedef struct {
    req_t        r;
    logic [31:0] exp_data;
    int          exp_code;
  } vec_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            flush = 1'b0;
  logic [ADDR_W:0] count;
  logic            err;
  logic [1:0]      err_code;

  instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

  instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE(BASE)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .bus(bus),
    .count(count), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (from the instruction-format rules) ----------
  function automatic longint fld(longint v, int hi, int lo);
    return (v >>> lo) & ((64'sd1 <<< (hi - lo + 1)) - 1);
  endfunction

  function automatic int ref_check(int kind, int alu, longint imm);
    bit alu_listed = (alu == 0 || alu == 1 || alu == 2 || alu == 3 || alu == 5);
    if (kind > 5) return 3;
    if (kind <= 1 && (!alu_listed || (kind == 1 && alu == 1))) return 1;
    if ((kind == 1 || kind == 2 || kind == 3) && (imm < -2048 || imm > 2047)) return 2;
    if (kind == 4 && (imm < -4096 || imm > 4094 || (imm & 1) != 0)) return 2;
    if (kind == 5 && (imm < -1048576 || imm > 1048574 || (imm & 1) != 0)) return 2;
    return 0;
  endfunction

  function automatic logic [31:0] ref_encode(int kind, int alu, int rd, int rs1, int rs2, longint imm);
    int     f3_of_alu [8] = '{0, 0, 7, 6, 0, 2, 0, 0};
    longint w = 0;
    longint f3 = f3_of_alu[alu & 7];
    case (kind)
      0: w = (alu == 1 ? 32 : 0) * 2**25 + rs2 * 2**20 + rs1 * 2**15 + f3 * 2**12 + rd * 128 + 51;
      1: w = fld(imm, 11, 0) * 2**20 + rs1 * 2**15 + f3 * 2**12 + rd * 128 + 19;
      2: w = fld(imm, 11, 0) * 2**20 + rs1 * 2**15 + 2 * 2**12 + rd * 128 + 3;
      3: w = fld(imm, 11, 5) * 2**25 + rs2 * 2**20 + rs1 * 2**15 + 2 * 2**12
             + fld(imm, 4, 0) * 128 + 35;
      4: w = fld(imm, 12, 12) * 64'sd2147483648 + fld(imm, 10, 5) * 2**25 + rs2 * 2**20
             + rs1 * 2**15 + fld(imm, 4, 1) * 256 + fld(imm, 11, 11) * 128 + 99;
      5: w = fld(imm, 20, 20) * 64'sd2147483648 + fld(imm, 10, 1) * 2**21
             + fld(imm, 11, 11) * 2**20 + fld(imm, 19, 12) * 2**12 + rd * 128 + 111;
      default: w = 0;
    endcase
    return w[31:0];
  endfunction

  function automatic int sat_count(int n);
    return (n > 2**ADDR_W) ? 2**ADDR_W : n;
  endfunction

  // ---------------- scoreboard / monitor ---------------------------------------
  bit   mon_en = 1'b0;
  exp_t exp_q[$];
  int   m_next_addr = 0;
  int   m_writes = 0;
  int   m_err = 0;
  exp_t m_head;
  int   m_code;

  task automatic model_clear();
    exp_q.delete();
    m_next_addr = int'(BASE);
    m_writes    = 0;
    m_err       = 0;
  endtask

  always @(negedge clk) begin
    if (mon_en && reset_n && !flush) begin
      if (bus.wr_en && bus.wr_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 64'd1, 64'd0);
        end else begin
          m_head = exp_q.pop_front();
          check("wr_addr", 64'(bus.wr_addr), 64'(m_head.addr));
          check("wr_data", 64'(bus.wr_data), 64'(m_head.data));
          check("count_at_write", 64'(count), 64'(sat_count(m_writes)));
          m_writes++;
        end
      end
      if (bus.req_valid && bus.req_ready) begin
        m_code = ref_check(int'(bus.req_kind), int'(bus.req_alu), longint'($signed(bus.req_imm)));
        if (m_code != 0) begin
          if (m_err == 0) m_err = m_code;
        end else begin
          exp_q.push_back('{addr: m_next_addr[ADDR_W-1:0],
                            data: ref_encode(int'(bus.req_kind), int'(bus.req_alu),
                                             int'(bus.req_rd), int'(bus.req_rs1),
                                             int'(bus.req_rs2),
                                             longint'($signed(bus.req_imm)))});
          m_next_addr++;
        end
      end
    end
  end

  // ---------------- stimulus helpers -------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put_req(input req_t r);
    bus.req_kind  = 3'(r.kind);
    bus.req_alu   = 3'(r.alu);
    bus.req_rd    = 5'(r.rd);
    bus.req_rs1   = 5'(r.rs1);
    bus.req_rs2   = 5'(r.rs2);
    bus.req_imm   = r.imm;
    bus.req_valid = 1'b1;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    bus.req_valid = 1'b0;
    step();
    flush = 1'b0;
    model_clear();
  endtask

  // Present one request and return one phase after the accepting edge.
  task automatic send(input req_t r);
    bit got = 1'b0;
    put_req(r);
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.req_ready) got = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.req_valid = 1'b0;
    if (!got) check("accept_timeout", 64'd0, 64'd1);
  endtask

  function automatic req_t mk_req(int k, int a, int rd, int rs1, int rs2, int imm);
    req_t r;
    r.kind = k; r.alu = a; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.imm = imm;
    return r;
  endfunction

  function automatic vec_t mk_vec(int k, int a, int rd, int rs1, int rs2, int imm,
                                  logic [31:0] d, int c);
    vec_t v;
    v.r = mk_req(k, a, rd, rs1, rs2, imm);
    v.exp_data = d;
    v.exp_code = c;
    return v;
  endfunction

  function automatic req_t gen_req(bit allow_bad);
    req_t r;
    int   alu_list [5] = '{0, 1, 2, 3, 5};
    int   p = int'($urandom_range(0, 99));
    r.kind = (allow_bad && p < 4) ? int'($urandom_range(6, 7)) : int'($urandom_range(0, 5));
    r.alu  = alu_list[$urandom_range(0, 4)];
    if (!allow_bad && r.kind == 1 && r.alu == 1) r.alu = 0;
    if (allow_bad && p >= 4 && p < 8) r.alu = int'($urandom_range(0, 7));
    r.rd  = int'($urandom_range(0, 31));
    r.rs1 = int'($urandom_range(0, 31));
    r.rs2 = int'($urandom_range(0, 31));
    case (r.kind)
      1, 2, 3: r.imm = int'($urandom_range(0, 4095)) - 2048;
      4:       r.imm = 2 * (int'($urandom_range(0, 4095)) - 2048);
      5:       r.imm = 2 * (int'($urandom_range(0, 1048575)) - 524288);
      default: r.imm = 0;
    endcase
    if (allow_bad && p >= 8 && p < 12) r.imm = int'($urandom());
    return r;
  endfunction

  // ---------------- test sequence ----------------------------------------------
  vec_t tbl [19];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_kind  = '0;
    bus.req_alu   = '0;
    bus.req_rd    = '0;
    bus.req_rs1   = '0;
    bus.req_rs2   = '0;
    bus.req_imm   = '0;
    bus.wr_ready  = 1'b0;

    tbl[0]  = mk_vec(1, 0, 1, 0, 0, 5,        32'h00500093, 0);  // addi
    tbl[1]  = mk_vec(0, 1, 3, 1, 2, 0,        32'h402081B3, 0);  // sub
    tbl[2]  = mk_vec(3, 0, 0, 1, 2, 8,        32'h0020A423, 0);  // sw
    tbl[3]  = mk_vec(4, 0, 0, 1, 2, -4,       32'hFE208EE3, 0);  // beq back
    tbl[4]  = mk_vec(5, 0, 1, 0, 0, 8,        32'h008000EF, 0);  // jal
    tbl[5]  = mk_vec(2, 0, 5, 6, 0, -4,       32'hFFC32283, 0);  // lw
    tbl[6]  = mk_vec(0, 2, 4, 5, 6, 0,        32'h0062F233, 0);  // and
    tbl[7]  = mk_vec(5, 0, 0, 0, 0, -1048576, 32'h8000006F, 0);  // jal min
    tbl[8]  = mk_vec(4, 0, 0, 0, 0, 4094,     32'h7E000FE3, 0);  // beq max
    tbl[9]  = mk_vec(1, 0, 1, 0, 0, 2048,     32'h0, 2);         // I imm too big
    tbl[10] = mk_vec(6, 0, 0, 0, 0, 0,        32'h0, 3);         // bad kind
    tbl[11] = mk_vec(0, 4, 1, 2, 3, 0,        32'h0, 1);         // bad alu
    tbl[12] = mk_vec(1, 1, 1, 0, 0, 5,        32'h0, 1);         // I with sub
    tbl[13] = mk_vec(4, 0, 0, 1, 2, 3,        32'h0, 2);         // beq odd
    tbl[14] = mk_vec(5, 0, 1, 0, 0, 1048576,  32'h0, 2);         // jal too far
    tbl[15] = mk_vec(7, 4, 0, 0, 0, 5000,     32'h0, 3);         // kind beats alu/imm
    tbl[16] = mk_vec(1, 7, 1, 0, 0, 5000,     32'h0, 1);         // alu beats imm
    tbl[17] = mk_vec(3, 0, 0, 1, 2, -2049,    32'h0, 2);         // sw below range
    tbl[18] = mk_vec(1, 5, 2, 3, 0, -2048,    32'h8001A113, 0);  // slti min imm

    // Reset state
    #12;
    check("rst_wr_en",     64'(bus.wr_en),     64'd0);
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check("rst_wr_data",   64'(bus.wr_data),   64'd0);
    check("rst_wr_addr",   64'(bus.wr_addr),   64'(BASE));
    check("rst_count",     64'(count),         64'd0);
    check("rst_err",       64'({err, err_code}), 64'd0);
    step();
    reset_n = 1'b1;
    step();

    // Table-driven single-request vectors
    for (int i = 0; i < 19; i++) begin
      do_flush();
      bus.wr_ready = 1'b0;
      send(tbl[i].r);
      if (tbl[i].exp_code == 0) begin
        @(negedge clk);
        check($sformatf("v%0d_wr_en_lat1", i), 64'(bus.wr_en), 64'd0);
        @(negedge clk);
        check($sformatf("v%0d_wr_en_lat2", i), 64'(bus.wr_en), 64'd1);
        check($sformatf("v%0d_wr_data", i),    64'(bus.wr_data), 64'(tbl[i].exp_data));
        check($sformatf("v%0d_wr_addr", i),    64'(bus.wr_addr), 64'(BASE));
        check($sformatf("v%0d_err", i),        64'(err), 64'd0);
        step();
        bus.wr_ready = 1'b1;
        step();
        bus.wr_ready = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d_count", i),      64'(count), 64'd1);
        check($sformatf("v%0d_empty", i),      64'(bus.wr_en), 64'd0);
      end else begin
        bit seen_wr = 1'b0;
        for (int c = 0; c < 4; c++) begin
          @(negedge clk);
          if (bus.wr_en) seen_wr = 1'b1;
        end
        check($sformatf("v%0d_no_write", i), 64'(seen_wr), 64'd0);
        check($sformatf("v%0d_err", i),      64'(err), 64'd1);
        check($sformatf("v%0d_err_code", i), 64'(err_code), 64'(tbl[i].exp_code));
      end
      step();
    end

    // Sticky error code, then flush restores the post-reset state
    do_flush();
    bus.wr_ready = 1'b1;
    send(mk_req(1, 0, 1, 0, 0, 5));
    repeat (3) step();
    send(mk_req(1, 0, 1, 0, 0, 2048));
    repeat (3) step();
    send(mk_req(7, 0, 0, 0, 0, 0));
    repeat (3) step();
    @(negedge clk);
    check("sticky_err",      64'(err), 64'd1);
    check("sticky_code",     64'(err_code), 64'd2);
    check("sticky_count",    64'(count), 64'd1);
    check("sticky_addr",     64'(bus.wr_addr), 64'(BASE + 8'd1));
    step();
    do_flush();
    @(negedge clk);
    check("flush_err",       64'({err, err_code}), 64'd0);
    check("flush_addr",      64'(bus.wr_addr), 64'(BASE));
    check("flush_count",     64'(count), 64'd0);
    check("flush_wr_en",     64'(bus.wr_en), 64'd0);
    step();

    // Back-pressure: six back-to-back requests with imem stalled
    begin
      req_t pend [6];
      int   idx = 0;
      int   acc = 0;
      bit   hs;
      do_flush();
      mon_en = 1'b1;
      bus.wr_ready = 1'b0;
      for (int i = 0; i < 6; i++) pend[i] = gen_req(1'b0);
      put_req(pend[0]);
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        hs = bus.req_valid && bus.req_ready;
        if (hs) acc++;
        @(posedge clk);
        #1;
        if (hs) begin
          idx++;
          if (idx < 6) put_req(pend[idx]);
          else bus.req_valid = 1'b0;
        end
      end
      @(negedge clk);
      check("bp_accepted",  64'(acc), 64'(DEPTH));
      check("bp_req_ready", 64'(bus.req_ready), 64'd0);
      check("bp_wr_stable", 64'(bus.wr_data), 64'(ref_encode(pend[0].kind, pend[0].alu,
                              pend[0].rd, pend[0].rs1, pend[0].rs2, longint'(pend[0].imm))));
      step();
      bus.wr_ready = 1'b1;
      for (int c = 0; c < 40 && idx < 6; c++) begin
        @(negedge clk);
        hs = bus.req_valid && bus.req_ready;
        @(posedge clk);
        #1;
        if (hs) begin
          idx++;
          if (idx < 6) put_req(pend[idx]);
          else bus.req_valid = 1'b0;
        end
      end
      for (int c = 0; c < 20 && (exp_q.size() != 0 || bus.wr_en); c++) step();
      check("bp_all_sent", 64'(idx), 64'd6);
      check("bp_drained",  64'(exp_q.size()), 64'd0);
      check("bp_count",    64'(count), 64'd6);
      mon_en = 1'b0;
    end

    // Reset with words queued
    do_flush();
    bus.wr_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(gen_req(1'b0));
    repeat (2) step();
    check("pre_rst_wr_en", 64'(bus.wr_en), 64'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_wr_en",     64'(bus.wr_en), 64'd0);
    check("mid_rst_req_ready", 64'(bus.req_ready), 64'd0);
    check("mid_rst_wr_data",   64'(bus.wr_data), 64'd0);
    step();
    step();
    reset_n = 1'b1;
    step();
    check("post_rst_wr_en", 64'(bus.wr_en), 64'd0);
    check("post_rst_addr",  64'(bus.wr_addr), 64'(BASE));
    send(mk_req(1, 0, 2, 0, 0, 7));
    @(negedge clk);
    @(negedge clk);
    check("post_rst_new_wr_en", 64'(bus.wr_en), 64'd1);
    check("post_rst_new_addr",  64'(bus.wr_addr), 64'(BASE));
    check("post_rst_new_data",  64'(bus.wr_data), 64'(ref_encode(1, 0, 2, 0, 0, 7)));
    step();

    // Randomized traffic against the reference model (reaches count saturation
    // and address wrap)
    begin
      bit hs;
      do_flush();
      mon_en = 1'b1;
      put_req(gen_req(1'b1));
      for (int c = 0; c < 900; c++) begin
        bus.wr_ready = ($urandom_range(0, 9) < 8);
        @(negedge clk);
        hs = bus.req_valid && bus.req_ready;
        @(posedge clk);
        #1;
        if (hs || !bus.req_valid) begin
          if ($urandom_range(0, 9) < 8) put_req(gen_req(1'b1));
          else bus.req_valid = 1'b0;
        end
      end
      bus.req_valid = 1'b0;
      bus.wr_ready  = 1'b1;
      for (int c = 0; c < 30 && (exp_q.size() != 0 || bus.wr_en); c++) step();
      @(negedge clk);
      check("rand_drained",  64'(exp_q.size()), 64'd0);
      check("rand_wr_en",    64'(bus.wr_en), 64'd0);
      check("rand_count",    64'(count), 64'(sat_count(m_writes)));
      check("rand_addr",     64'(bus.wr_addr), 64'(m_next_addr % (2**ADDR_W)));
      check("rand_err",      64'(err), 64'(m_err != 0));
      check("rand_err_code", 64'(err_code), 64'(m_err));
      mon_en = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
